// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter slice.
// Optional build macro: BCD2BIN_CHECK_EN (per-digit range check, see bcd2binary_seq).
package bcd_pkg;

    // Number of packed BCD digits and result width (9999 fits in 14 bits).
    localparam int unsigned NDIGITS     = 4;
    localparam int unsigned BIN_W       = 14;
    localparam int unsigned BCD_W       = 4 * NDIGITS;

    // Largest decimal value representable by NDIGITS valid BCD digits.
    localparam int unsigned MAX_BCD_DEC = 9999;

    // Largest legal value of a single BCD digit.
    localparam logic [3:0]  DIGIT_MAX   = 4'd9;

    // Converter control states.
    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    // True when a nibble is not a legal BCD digit.
    function automatic logic digit_invalid(input logic [3:0] digit);
        return digit > DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One step of the decimal accumulator: acc_out = acc_in * 10 + digit, BIN_W wide.
// Optional build macro: BCD2BIN_CHECK_EN adds the digit_bad output (digit > 9).
module bcd_digit_mac #(
    parameter int unsigned BIN_W = 14
) (
    input  logic [BIN_W-1:0] acc_in,
    input  logic [3:0]       digit,
`ifdef BCD2BIN_CHECK_EN
    output logic             digit_bad,
`endif
    output logic [BIN_W-1:0] acc_out
);
    import bcd_pkg::*;

    // Four guard bits hold the full *10 + digit before truncation.
    localparam int unsigned WIDE_W = BIN_W + 4;

    logic [WIDE_W-1:0] acc_wide;
    logic [WIDE_W-1:0] digit_wide;

    // Multiply by 10 as (x<<3)+(x<<1), add the digit, keep the low BIN_W bits.
    always_comb begin
        acc_wide   = {4'b0000, acc_in};
        digit_wide = {{(WIDE_W-4){1'b0}}, digit};
        acc_out    = BIN_W'((acc_wide << 3) + (acc_wide << 1) + digit_wide);
    end

`ifdef BCD2BIN_CHECK_EN
    // Flag nibbles outside 0..9.
    always_comb begin
        digit_bad = digit_invalid(digit);
    end
`endif

endmodule

// File: rtl/bcd2binary_seq.sv
// Sequential packed-BCD to binary converter: one digit per clock, MSD first.
// start is accepted only in IDLE; done pulses for one cycle with out_binary/err valid.
// Optional build macro: BCD2BIN_CHECK_EN enables the digit > 9 error flag
// (err=1 forces out_binary to 0); without it err is constant 0.
module bcd2binary_seq #(
    parameter int unsigned NDIGITS = 4,
    parameter int unsigned BIN_W   = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   packed_bcd,
    output logic                   busy,
    output logic                   done,
    output logic [BIN_W-1:0]       out_binary,
    output logic                   err
);
    import bcd_pkg::*;

    localparam int unsigned SR_W  = 4 * NDIGITS;
    localparam int unsigned CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    state_e             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [BIN_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BIN_W-1:0]   out_q, out_d;
    logic               err_q, err_d;

    logic [3:0]         digit;
    logic [BIN_W-1:0]   mac_out;
    logic               last_digit;

`ifdef BCD2BIN_CHECK_EN
    logic               flag_q, flag_d;
    logic               digit_bad;
`endif

    assign digit      = sr_q[SR_W-1 -: 4];
    assign last_digit = (cnt_q == CNT_W'(NDIGITS - 1));

    bcd_digit_mac #(
        .BIN_W (BIN_W)
    ) u_mac (
        .acc_in    (acc_q),
        .digit     (digit),
`ifdef BCD2BIN_CHECK_EN
        .digit_bad (digit_bad),
`endif
        .acc_out   (mac_out)
    );

    // Next-state logic: capture in IDLE, accumulate one digit per cycle in CONV.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        err_d   = err_q;
`ifdef BCD2BIN_CHECK_EN
        flag_d  = flag_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = packed_bcd;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
`ifdef BCD2BIN_CHECK_EN
                    flag_d  = 1'b0;
`endif
                end
            end
            CONV: begin
                acc_d = mac_out;
                sr_d  = sr_q << 4;
                cnt_d = cnt_q + CNT_W'(1);
`ifdef BCD2BIN_CHECK_EN
                flag_d = flag_q | digit_bad;
`endif
                if (last_digit) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef BCD2BIN_CHECK_EN
                    // The final digit's check has not reached flag_q yet, so fold it in here.
                    err_d   = flag_q | digit_bad;
                    out_d   = (flag_q | digit_bad) ? '0 : mac_out;
`else
                    err_d   = 1'b0;
                    out_d   = mac_out;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; synchronous reset discards any conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            err_q   <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
            flag_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            err_q   <= err_d;
`ifdef BCD2BIN_CHECK_EN
            flag_q  <= flag_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign out_binary = out_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bcd2binary_seq.sv
// Scoreboard bench for bcd2binary_seq; expectations follow BCD2BIN_CHECK_EN if defined.
module tb_bcd2binary_seq;

    typedef struct {
        logic [13:0] bin;
        logic        err;
        logic [15:0] bcd;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] packed_bcd;
    logic        busy;
    logic        done;
    logic [13:0] out_binary;
    logic        err;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nmis = 0;
    int   ndone = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;

    bcd2binary_seq #(
        .NDIGITS (4),
        .BIN_W   (14)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .packed_bcd (packed_bcd),
        .busy       (busy),
        .done       (done),
        .out_binary (out_binary),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: positional decimal weights, result taken modulo 2^14.
    function automatic exp_t model(input logic [15:0] bcd);
        exp_t e;
        int   val;
        logic bad;
        val = 1000 * int'(bcd[15:12]) + 100 * int'(bcd[11:8])
            + 10 * int'(bcd[7:4]) + int'(bcd[3:0]);
        bad = (bcd[15:12] > 4'd9) || (bcd[11:8] > 4'd9)
           || (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
        e.bcd = bcd;
        e.bin = 14'(val % 16384);
`ifdef BCD2BIN_CHECK_EN
        e.err = bad;
        if (bad) e.bin = '0;
`else
        e.err = 1'b0;
        if (bad) e.bin = 14'(val % 16384);
`endif
        return e;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] b;
        b[15:12] = 4'((n / 1000) % 10);
        b[11:8]  = 4'((n / 100) % 10);
        b[7:4]   = 4'((n / 10) % 10);
        b[3:0]   = 4'(n % 10);
        return b;
    endfunction

    // Result checker: every done pops one expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            ndone = ndone + 1;
            last_done_cyc = cyc;
            nvec = nvec + 1;
            if (busy !== 1'b0) begin
                nmis = nmis + 1;
                $display("FAIL busy_with_done: busy=%b required 0 at cycle %0d", busy, cyc);
            end
            nvec = nvec + 1;
            if (exp_q.size() == 0) begin
                nmis = nmis + 1;
                $display("FAIL unexpected_done: out_binary=%0d err=%b, no conversion pending", out_binary, err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_binary !== e.bin || err !== e.err) begin
                    nmis = nmis + 1;
                    $display("FAIL result_%h: out_binary=%0d err=%b required %0d err=%b",
                             e.bcd, out_binary, err, e.bin, e.err);
                end
            end
        end
    end

    task automatic push(input logic [15:0] bcd);
        exp_q.push_back(model(bcd));
    endtask

    // Drive a one-cycle start; returns just after the accepting edge.
    task automatic pulse_start(input logic [15:0] bcd);
        @(posedge clk);
        #1;
        packed_bcd = bcd;
        start      = 1'b1;
        push(bcd);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (exp_q.size() == 0) ok = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        packed_bcd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec = nvec + 1;
        if (busy !== 1'b0) begin nmis = nmis + 1; $display("FAIL reset_busy: busy=%b required 0", busy); end
        nvec = nvec + 1;
        if (done !== 1'b0) begin nmis = nmis + 1; $display("FAIL reset_done: done=%b required 0", done); end
        nvec = nvec + 1;
        if (out_binary !== 14'd0) begin nmis = nmis + 1; $display("FAIL reset_out: out_binary=%0d required 0", out_binary); end
        nvec = nvec + 1;
        if (err !== 1'b0) begin nmis = nmis + 1; $display("FAIL reset_err: err=%b required 0", err); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int lat = 0;
        int nb  = 0;
        pulse_start(16'h1234);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy === 1'b1) nb++;
        end
        nvec = nvec + 1;
        if (lat !== 5) begin
            nmis = nmis + 1;
            $display("FAIL latency_1234: done seen %0d cycles after accept (0=never), required 5", lat);
        end
        nvec = nvec + 1;
        if (nb !== 4) begin
            nmis = nmis + 1;
            $display("FAIL busy_len_1234: busy cycles=%0d required 4", nb);
        end
        @(negedge clk);
        nvec = nvec + 1;
        if (done !== 1'b0) begin
            nmis = nmis + 1;
            $display("FAIL done_width_1234: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_values;
        logic [15:0] vals [4];
        bit ok;
        vals[0] = 16'h9999;
        vals[1] = 16'h0000;
        vals[2] = 16'h0001;
        vals[3] = 16'h1000;
        for (int i = 0; i < 4; i++) begin
            pulse_start(vals[i]);
            drain(20, ok);
            nvec = nvec + 1;
            if (ok !== 1'b1) begin
                nmis = nmis + 1;
                $display("FAIL timeout_%h: pending=%0d required 0", vals[i], exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic test_back_to_back;
        int  c0 = 0;
        int  d0;
        bit  ok;
        d0 = ndone;
        @(posedge clk);
        #1;
        start = 1'b1;
        packed_bcd = to_bcd(0);
        push(packed_bcd);
        for (int i = 0; i <= 9999; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) c0 = cyc;
            if (i < 9999) begin
                packed_bcd = to_bcd(i + 1);
                push(packed_bcd);
                repeat (4) @(posedge clk);
            end else begin
                start = 1'b0;
            end
        end
        drain(20, ok);
        nvec = nvec + 1;
        if (ok !== 1'b1) begin
            nmis = nmis + 1;
            $display("FAIL timeout_b2b: pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        nvec = nvec + 1;
        if (ndone - d0 !== 10000) begin
            nmis = nmis + 1;
            $display("FAIL b2b_count: done pulses=%0d required 10000", ndone - d0);
        end
        nvec = nvec + 1;
        if (last_done_cyc !== c0 + 5 * 9999 + 4) begin
            nmis = nmis + 1;
            $display("FAIL b2b_rate: last done at cycle %0d required %0d", last_done_cyc, c0 + 5 * 9999 + 4);
        end
    endtask

    task automatic test_invalid;
        bit ok;
        pulse_start(16'h12A4);
        drain(20, ok);
        nvec = nvec + 1;
        if (ok !== 1'b1) begin nmis = nmis + 1; $display("FAIL timeout_12a4: pending=%0d required 0", exp_q.size()); exp_q.delete(); end
        pulse_start(16'h0042);
        drain(20, ok);
        nvec = nvec + 1;
        if (ok !== 1'b1) begin nmis = nmis + 1; $display("FAIL timeout_0042: pending=%0d required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_start_while_busy;
        int d0;
        bit ok;
        @(posedge clk);
        #1;
        start = 1'b1;
        packed_bcd = 16'h0007;
        push(16'h0007);
        @(posedge clk);
        #1;
        d0 = ndone;
        packed_bcd = 16'h5555;
        push(16'h5555);
        repeat (4) @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        nvec = nvec + 1;
        if (ndone - d0 !== 1) begin
            nmis = nmis + 1;
            $display("FAIL busy_ignore: done pulses=%0d during first conversion, required 1", ndone - d0);
        end
        drain(20, ok);
        nvec = nvec + 1;
        if (ok !== 1'b1) begin nmis = nmis + 1; $display("FAIL timeout_5555: pending=%0d required 0", exp_q.size()); exp_q.delete(); end
        nvec = nvec + 1;
        if (ndone - d0 !== 2) begin
            nmis = nmis + 1;
            $display("FAIL busy_ignore_total: done pulses=%0d required 2", ndone - d0);
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        bit ok;
        @(posedge clk);
        #1;
        packed_bcd = 16'h8888;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        d0 = ndone;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nvec = nvec + 1;
        if (busy !== 1'b0 || done !== 1'b0 || out_binary !== 14'd0 || err !== 1'b0) begin
            nmis = nmis + 1;
            $display("FAIL mid_reset_outs: busy=%b done=%b out_binary=%0d err=%b required all 0",
                     busy, done, out_binary, err);
        end
        reset = 1'b0;
        repeat (6) @(negedge clk);
        nvec = nvec + 1;
        if (ndone !== d0) begin
            nmis = nmis + 1;
            $display("FAIL mid_reset_done: done pulses=%0d after reset, required 0", ndone - d0);
        end
        pulse_start(16'h0010);
        drain(20, ok);
        nvec = nvec + 1;
        if (ok !== 1'b1) begin nmis = nmis + 1; $display("FAIL timeout_0010: pending=%0d required 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_back_to_back();
        test_invalid();
        test_start_while_busy();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
